// File: rtl/mdr_result_bcd_pkg.sv
// Shared types and constants for the MDR result-to-BCD display stage.
// DW/DIGITS must satisfy 10**DIGITS > 2**(DW-1) so the largest magnitude fits.
package mdr_result_bcd_pkg;

    localparam int DW     = 16;
    localparam int DIGITS = 5;
    localparam int BCD_W  = 4 * DIGITS;
    localparam int CNT_W  = $clog2(DW);

    typedef logic [DW-1:0]    data_t;
    typedef logic [BCD_W-1:0] bcd_t;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } bcd_state_e;

    // Two's-complement magnitude; the most negative value maps to 2**(DW-1) unsigned.
    function automatic data_t magnitude(input data_t value);
        return value[DW-1] ? (~value + data_t'(1)) : value;
    endfunction

endpackage

// File: rtl/mdr_result_bcd_add3.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift.
module bcd_add3 (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= 4'd5) begin
            digit_o = digit_i + 4'd3;
        end
    end

endmodule

// File: rtl/mdr_result_bcd.sv
// Display stage: latches a signed MDR result or error and converts the magnitude
// to packed BCD one bit per clock, holding the result for the 7-segment driver.
module mdr_result_bcd
    import mdr_result_bcd_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [DW-1:0]     i_result,
    input  logic              i_error,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_sign,
    output logic [BCD_W-1:0]  o_bcd,
    output logic              o_error_disp
);

    bcd_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    data_t             mag_q;
    bcd_t              scratch_q;
    logic              sign_q;

    bcd_t              scratchAdj;
    bcd_t              scratch_d;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : gAdd3
            bcd_add3 uAdd3 (
                .digit_i (scratch_q[4*g +: 4]),
                .digit_o (scratchAdj[4*g +: 4])
            );
        end
    endgenerate

    assign scratch_d = {scratchAdj[BCD_W-2:0], mag_q[DW-1]};

    assign o_busy = (state_q != IDLE);

    // Outputs are loaded on the edge that enters DONE so o_done and the new values
    // appear together; DONE itself only returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mag_q        <= '0;
            scratch_q    <= '0;
            sign_q       <= 1'b0;
            o_done       <= 1'b0;
            o_sign       <= 1'b0;
            o_bcd        <= '0;
            o_error_disp <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        if (i_error) begin
                            o_bcd        <= {DIGITS{BCD_BLANK}};
                            o_sign       <= 1'b0;
                            o_error_disp <= 1'b1;
                            o_done       <= 1'b1;
                            state_q      <= DONE;
                        end else begin
                            sign_q    <= i_result[DW-1];
                            mag_q     <= magnitude(i_result);
                            scratch_q <= '0;
                            cnt_q     <= '0;
                            state_q   <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    scratch_q <= scratch_d;
                    mag_q     <= {mag_q[DW-2:0], 1'b0};
                    cnt_q     <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DW - 1)) begin
                        // A zero magnitude never shows a minus sign.
                        o_bcd        <= scratch_d;
                        o_sign       <= sign_q & (scratch_d != '0);
                        o_error_disp <= 1'b0;
                        o_done       <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdr_result_bcd.sv
// Randomized self-checking bench for mdr_result_bcd against a decimal-arithmetic model.
module tb_mdr_result_bcd;

    localparam int DW     = 16;
    localparam int DIGITS = 5;

    logic                 clk;
    logic                 rst;
    logic                 i_valid;
    logic [DW-1:0]        i_result;
    logic                 i_error;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_sign;
    logic [4*DIGITS-1:0]  o_bcd;
    logic                 o_error_disp;

    int checks = 0;
    int errors = 0;

    mdr_result_bcd dut (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (i_valid),
        .i_result     (i_result),
        .i_error      (i_error),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_sign       (o_sign),
        .o_bcd        (o_bcd),
        .o_error_disp (o_error_disp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish (got timeout, expected finish)");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference model: plain decimal digit extraction of the signed value's magnitude.
    function automatic logic [31:0] modelBcd(input logic [DW-1:0] value, input logic err);
        int mag;
        logic [31:0] bcd;
        if (err) return 32'h000FFFFF;
        mag = $signed(value);
        if (mag < 0) mag = -mag;
        bcd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            bcd = bcd | (32'(mag % 10) << (4 * i));
            mag = mag / 10;
        end
        return bcd;
    endfunction

    function automatic logic modelSign(input logic [DW-1:0] value, input logic err);
        return !err && ($signed(value) < 0);
    endfunction

    task automatic applyReset();
        rst     = 1'b1;
        i_valid = 1'b0;
        i_error = 1'b0;
        i_result = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives one transaction; pulseAt > 0 injects a stray i_valid while busy.
    task automatic applyStimulus(input logic [DW-1:0] res, input logic err, input int pulseAt);
        int edges;
        int busyCnt;
        int extraDone;
        logic [31:0] expBcd;
        expBcd = modelBcd(res, err);
        @(negedge clk);
        i_valid  = 1'b1;
        i_result = res;
        i_error  = err;
        @(negedge clk);
        i_valid = 1'b0;
        edges   = 1;
        busyCnt = 0;
        while (!o_done && edges < 40) begin
            if (o_busy) busyCnt++;
            if (edges == pulseAt) begin
                i_valid  = 1'b1;
                i_result = DW'($urandom);
                i_error  = 1'($urandom);
            end else begin
                i_valid = 1'b0;
            end
            @(negedge clk);
            edges++;
        end
        i_valid = 1'b0;
        checkOutput("latency", edges, err ? 1 : DW + 1);
        checkOutput("done", o_done, 1);
        checkOutput("bcd", o_bcd, expBcd);
        checkOutput("sign", o_sign, modelSign(res, err));
        checkOutput("error_disp", o_error_disp, err);
        if (!err) checkOutput("busy_cycles", busyCnt, DW);
        extraDone = 0;
        @(negedge clk);
        checkOutput("busy_after_done", o_busy, 0);
        for (int i = 0; i < 3; i++) begin
            if (o_done) extraDone++;
            @(negedge clk);
        end
        checkOutput("extra_done", extraDone, 0);
        checkOutput("bcd_hold", o_bcd, expBcd);
    endtask

    initial begin
        logic [DW-1:0] r;
        int doneCnt;
        i_valid  = 1'b0;
        i_error  = 1'b0;
        i_result = '0;
        rst      = 1'b1;
        applyReset();
        checkOutput("reset_bcd", o_bcd, 0);
        checkOutput("reset_sign", o_sign, 0);
        checkOutput("reset_err", o_error_disp, 0);
        checkOutput("reset_busy", o_busy, 0);
        checkOutput("reset_done", o_done, 0);

        applyStimulus(16'd12345, 1'b0, -1);
        applyStimulus(16'hFFFF, 1'b0, -1);
        applyStimulus(16'h8000, 1'b0, -1);
        applyStimulus(16'h0000, 1'b0, -1);
        applyStimulus(16'h7FFF, 1'b0, -1);
        applyStimulus(16'h1234, 1'b1, -1);
        applyStimulus(16'd7, 1'b0, -1);
        applyStimulus(16'd999, 1'b0, 5);

        // Reset partway through a conversion must abort it silently.
        @(negedge clk);
        i_valid  = 1'b1;
        i_result = 16'd999;
        i_error  = 1'b0;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midreset_bcd", o_bcd, 0);
        checkOutput("midreset_busy", o_busy, 0);
        checkOutput("midreset_sign", o_sign, 0);
        doneCnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (o_done) doneCnt++;
            @(negedge clk);
        end
        checkOutput("midreset_no_done", doneCnt, 0);
        applyStimulus(16'd42, 1'b0, -1);

        for (int n = 0; n < 40; n++) begin
            r = DW'($urandom);
            applyStimulus(r, ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
